// File: rtl/ls_pat_gen.sv
// ls_pat_gen: serial pattern generator for shift-register chain testing.
// Sequence: zero flush, one-cycle start marker, one gap cycle, RUN_LEN pattern
// bits, then a one-cycle DONE.
// Optional macro LS_PAT_GEN_PRBS_EN adds a PRBS7 (x^7+x^6+1) source for MODE=11.
// Without it, MODE=11 falls back to the alternating pattern.
module ls_pat_gen #(
    parameter int FLUSH_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START_i,
    input  logic [1:0]       MODE_i,
    input  logic [CNT_W-1:0] RUN_LEN_i,
    output logic             D_o,
    output logic             DATA_o,
    output logic             DATA_VLD_o,
    output logic             BUSY_o,
    output logic             DONE_o,
    output logic [CNT_W-1:0] BIT_CNT_o
);

    typedef enum logic [2:0] {IDLE, FLUSH, MARK, GAP, RUN, FIN} state_t;

    localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] rlen_q, rlen_d;
    logic [1:0]       mode_q, mode_d;
    logic             alt_q, alt_d;
    logic             pat_bit;
    logic             accept;
    logic             run_nxt;
    logic             d_d, data_d, vld_d, busy_d, done_d;
`ifdef LS_PAT_GEN_PRBS_EN
    logic [6:0]       lfsr_q, lfsr_d;
`endif

    assign accept  = (state_q == IDLE) && START_i;
    assign run_nxt = (state_d == RUN);

    // Current pattern bit from the latched mode
    always_comb begin
        case (mode_q)
            2'b00:   pat_bit = 1'b0;
            2'b01:   pat_bit = 1'b1;
            2'b10:   pat_bit = alt_q;
`ifdef LS_PAT_GEN_PRBS_EN
            default: pat_bit = lfsr_q[6];
`else
            default: pat_bit = alt_q;
`endif
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; BIT_CNT equals bits emitted so far while in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START_i) state_d = FLUSH;
            FLUSH:   if (fcnt_q == FL_LAST) state_d = MARK;
            MARK:    state_d = GAP;
            GAP:     state_d = (rlen_q != '0) ? RUN : FIN;
            RUN:     if (bcnt_q == rlen_q) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and pattern source: load on accept, advance once per emitted bit
    always_comb begin
        fcnt_d = fcnt_q;
        bcnt_d = bcnt_q;
        rlen_d = rlen_q;
        mode_d = mode_q;
        alt_d  = alt_q;
`ifdef LS_PAT_GEN_PRBS_EN
        lfsr_d = lfsr_q;
`endif
        if (accept) begin
            fcnt_d = '0;
            bcnt_d = '0;
            rlen_d = RUN_LEN_i;
            mode_d = MODE_i;
            alt_d  = 1'b1;
`ifdef LS_PAT_GEN_PRBS_EN
            lfsr_d = 7'h7F;
`endif
        end else begin
            if (state_q == FLUSH) fcnt_d = fcnt_q + CNT_W'(1);
            if (run_nxt) begin
                bcnt_d = bcnt_q + CNT_W'(1);
                alt_d  = ~alt_q;
`ifdef LS_PAT_GEN_PRBS_EN
                lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
            end
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fcnt_q <= '0;
            bcnt_q <= '0;
            rlen_q <= '0;
            mode_q <= 2'b00;
            alt_q  <= 1'b1;
`ifdef LS_PAT_GEN_PRBS_EN
            lfsr_q <= 7'h7F;
`endif
        end else begin
            fcnt_q <= fcnt_d;
            bcnt_q <= bcnt_d;
            rlen_q <= rlen_d;
            mode_q <= mode_d;
            alt_q  <= alt_d;
`ifdef LS_PAT_GEN_PRBS_EN
            lfsr_q <= lfsr_d;
`endif
        end
    end

    // FSM output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        d_d    = (state_d == MARK) | (run_nxt & pat_bit);
        data_d = run_nxt & pat_bit;
        vld_d  = run_nxt;
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // Output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            D_o        <= 1'b0;
            DATA_o     <= 1'b0;
            DATA_VLD_o <= 1'b0;
            BUSY_o     <= 1'b0;
            DONE_o     <= 1'b0;
        end else begin
            D_o        <= d_d;
            DATA_o     <= data_d;
            DATA_VLD_o <= vld_d;
            BUSY_o     <= busy_d;
            DONE_o     <= done_d;
        end
    end

    assign BIT_CNT_o = bcnt_q;

endmodule

// File: tb/tb_ls_pat_gen.sv
// tb_ls_pat_gen: randomized and directed stimulus against a queue-based model
// of the expected per-cycle output stream of ls_pat_gen.
module tb_ls_pat_gen;

    localparam int FL    = 4;
    localparam int CNT_W = 8;

    logic             CLK, RST, START;
    logic [1:0]       MODE;
    logic [CNT_W-1:0] RUN_LEN;
    logic             D_o, DATA_o, DATA_VLD_o, BUSY_o, DONE_o;
    logic [CNT_W-1:0] BIT_CNT_o;

    ls_pat_gen #(.FLUSH_LEN(FL), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .START_i(START), .MODE_i(MODE), .RUN_LEN_i(RUN_LEN),
        .D_o(D_o), .DATA_o(DATA_o), .DATA_VLD_o(DATA_VLD_o), .BUSY_o(BUSY_o),
        .DONE_o(DONE_o), .BIT_CNT_o(BIT_CNT_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic             d, data, vld, busy, done;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    exp_t ex;
    logic [CNT_W-1:0] last_cnt;
    logic prbs [0:126];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // PRBS7 output stream from its recurrence o[n] = o[n-7] ^ o[n-6]
    initial begin
        for (int i = 0; i < 127; i++)
            prbs[i] = (i < 7) ? 1'b1 : (prbs[i-7] ^ prbs[i-6]);
    end

    function automatic logic pat(input logic [1:0] m, input int i);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return (i % 2) == 0;
`ifdef LS_PAT_GEN_PRBS_EN
            default: return prbs[i % 127];
`else
            default: return (i % 2) == 0;
`endif
        endcase
    endfunction

    // Queue up the whole expected output stream of one accepted sequence
    task automatic build(input logic [1:0] m, input logic [CNT_W-1:0] rl);
        for (int i = 0; i < FL; i++) expq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0});
        expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0});
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0});
        for (int i = 0; i < int'(rl); i++) begin
            logic b;
            b = pat(m, i);
            expq.push_back('{b, b, 1'b1, 1'b1, 1'b0, CNT_W'(i + 1)});
        end
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rl});
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rl});
        last_cnt = rl;
    endtask

    // Model: advances one expected cycle per clock edge, clears on reset
    initial begin
        ex = '0;
        last_cnt = '0;
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                expq.delete();
                ex = '0;
                last_cnt = '0;
            end else begin
                if (expq.size() == 0 && START) build(MODE, RUN_LEN);
                if (expq.size() > 0) ex = expq.pop_front();
                else ex = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_cnt};
            end
        end
    end

    // Compare every cycle on the falling edge
    initial begin
        forever begin
            @(negedge CLK);
            chk("cyc_D",        D_o,        ex.d);
            chk("cyc_DATA",     DATA_o,     ex.data);
            chk("cyc_DATA_VLD", DATA_VLD_o, ex.vld);
            chk("cyc_BUSY",     BUSY_o,     ex.busy);
            chk("cyc_DONE",     DONE_o,     ex.done);
            chk("cyc_BIT_CNT",  BIT_CNT_o,  ex.cnt);
        end
    end

    // One START pulse; lat = cycle index of DONE counting the first FLUSH cycle as 1
    task automatic run_seq(input logic [1:0] m, input int rl, output int lat,
                           output logic [31:0] dc, output int vc);
        lat = -1;
        dc  = '0;
        vc  = 0;
        @(posedge CLK); #2;
        START = 1'b1; MODE = m; RUN_LEN = CNT_W'(rl);
        @(posedge CLK); #2;
        START = 1'b0; MODE = ~m; RUN_LEN = ~RUN_LEN;
        for (int n = 1; n <= 400; n++) begin
            @(negedge CLK);
            dc = {dc[30:0], D_o};
            if (DATA_VLD_o) vc++;
            if (DONE_o) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=none required=DONE t=%0t", $time);
        end
    endtask

    int          lat, vc, ones, dn;
    logic [31:0] dc;
    logic [7:0]  first8;
    logic        found;

    initial begin
        RST = 1'b1; START = 1'b0; MODE = 2'b00; RUN_LEN = '0;
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
        chk("reset_busy", BUSY_o, 0);
        chk("reset_bitcnt", BIT_CNT_o, 0);
        chk("reset_d", D_o, 0);

        // pin the model's PRBS7 table
        ones = 0;
        for (int i = 0; i < 127; i++) if (prbs[i]) ones++;
        for (int i = 0; i < 8; i++) first8[7-i] = prbs[i];
        chk("prbs_ones", ones, 64);
        chk("prbs_first8", first8, 8'b1111_1110);

        // all-1, short run: exact D waveform
        run_seq(2'b01, 3, lat, dc, vc);
        chk("mode1_d_wave", dc[9:0], 10'b00001_01110);
        chk("mode1_vld_cycles", vc, 3);
        chk("mode1_done_lat", lat, 10);
        chk("mode1_bitcnt", BIT_CNT_o, 3);

        // alternating
        run_seq(2'b10, 5, lat, dc, vc);
        chk("alt_done_lat", lat, 12);
        chk("alt_run_d", dc[5:1], 5'b10101);

        // zero-length run
        run_seq(2'b01, 0, lat, dc, vc);
        chk("rl0_done_lat", lat, FL + 3);
        chk("rl0_vld_cycles", vc, 0);
        chk("rl0_bitcnt", BIT_CNT_o, 0);

        // MODE=11, full PRBS period (or alternating fallback)
        run_seq(2'b11, 127, lat, dc, vc);
        chk("m3_done_lat", lat, FL + 127 + 3);
        chk("m3_vld_cycles", vc, 127);

        // maximum run length for this width
        run_seq(2'b01, 255, lat, dc, vc);
        chk("max_done_lat", lat, FL + 255 + 3);
        chk("max_bitcnt", BIT_CNT_o, 255);

        // reset at run bit 2
        @(posedge CLK); #2;
        START = 1'b1; MODE = 2'b01; RUN_LEN = 8'd10;
        @(posedge CLK); #2;
        START = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge CLK);
            if (DATA_VLD_o && BIT_CNT_o == 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reach_bit2", found, 1);
        #1 RST = 1'b1;
        #1;
        chk("rst_async_d", D_o, 0);
        chk("rst_async_vld", DATA_VLD_o, 0);
        chk("rst_async_busy", BUSY_o, 0);
        chk("rst_async_done", DONE_o, 0);
        chk("rst_async_cnt", BIT_CNT_o, 0);
        @(posedge CLK); #2 RST = 1'b0;
        run_seq(2'b01, 4, lat, dc, vc);
        chk("post_rst_lat", lat, FL + 4 + 3);
        chk("post_rst_bitcnt", BIT_CNT_o, 4);

        // START held high: back-to-back with one IDLE cycle
        @(posedge CLK); #2;
        START = 1'b1; MODE = 2'b10; RUN_LEN = 8'd2;
        dn = 0;
        for (int n = 0; n < 31; n++) begin
            @(negedge CLK);
            if (DONE_o) dn++;
        end
        chk("held_done_count", dn, 3);
        @(posedge CLK); #2 START = 1'b0;
        repeat (40) @(posedge CLK);

        // random traffic: START pulses land anywhere, MODE/RUN_LEN wiggle every cycle
        for (int c = 0; c < 1500; c++) begin
            @(posedge CLK); #2;
            START   = ($urandom_range(0, 3) == 0);
            MODE    = 2'($urandom);
            RUN_LEN = CNT_W'($urandom_range(0, 12));
        end
        @(posedge CLK); #2 START = 1'b0;
        repeat (60) @(posedge CLK);
        @(negedge CLK);
        chk("final_idle", BUSY_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
